if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Instruction-fetch front end. It is the producer side of the IF/ID pipeline register.
//  - Owns the fetch PC.
//  - Issues one outstanding request at a time to instruction memory (req/gnt, then rvalid).
//  - Presents {pc_out, instruction_out} to the IF/ID register, which captures them every
//    cycle it is not frozen or flushed.
//  - Honours the same freeze (stall) and branch redirect (flush) signals that drive the
//    IF/ID register, so no instruction is lost or duplicated.
// PARAMETERS
//  RESET_PC   32'h0000_0000  fetch address after reset
//  NOP_INSTR  32'h0000_0000  word driven on instruction_out when no valid fetch
// PORTS
//  clk              in   1   clock, rising edge
//  rst              in   1   reset, asynchronous, active-high
//  freeze           in   1   downstream stall; instruction not consumed this cycle
//  branch_taken     in   1   redirect fetch; same signal flushes IF/ID
//  branch_addr      in   32  redirect target; bits[1:0] forced to 0
//  imem_req         out  1   request valid
//  imem_addr        out  32  request word address (byte address, bits[1:0]=0)
//  imem_gnt         in   1   request accepted this cycle (only meaningful with imem_req)
//  imem_rvalid      in   1   response data valid, >=1 cycle after gnt
//  imem_rdata       in   32  response instruction word
//  pc_out           out  32  fetched instruction address + 4; 0 when fetch_valid=0
//  instruction_out  out  32  fetched word; NOP_INSTR when fetch_valid=0
//  fetch_valid      out  1   pc_out/instruction_out hold a real instruction
// BEHAVIOUR
//  State: fetch_pc (32b), state in {REQ, WAIT, HOLD, DROP}, hold_pc, hold_instr.
//  Reset (async): state=REQ, fetch_pc=RESET_PC, hold buffer cleared.
//   While rst high: imem_req=0, fetch_valid=0, pc_out=0, instruction_out=NOP_INSTR.
//   imem_addr = fetch_pc.
//  REQ:  imem_req=1, imem_addr=fetch_pc; gnt -> WAIT. Address may change before gnt.
//  WAIT: rvalid & !freeze -> word presented combinationally this cycle
//        (fetch_valid=1, pc_out=fetch_pc+4); fetch_pc+=4; -> REQ.
//        rvalid & freeze  -> capture into hold regs; -> HOLD.
//  HOLD: outputs driven from hold regs, fetch_valid=1, imem_req=0;
//        !freeze -> consumed, fetch_pc+=4, -> REQ.
//  DROP: waiting for a squashed response. imem_req=0, fetch_valid=0;
//        rvalid -> data discarded, -> REQ.
//  Consumption = fetch_valid & !freeze at a clock edge. Each word is consumed exactly once.
//  Branch (branch_taken=1) has priority over freeze and over normal transitions:
//   - fetch_valid forced 0 that cycle; fetch_pc <= {branch_addr[31:2],2'b00}.
//   - REQ & !gnt: -> REQ (new address next cycle).
//   - REQ & gnt: old address accepted; -> DROP.
//   - WAIT & rvalid: response discarded; -> REQ.
//   - WAIT & !rvalid: -> DROP.
//   - HOLD: buffer discarded; -> REQ.
//   - DROP: stay DROP; newest target kept.
//  Latency: >=2 cycles from request to presentation. Throughput <=1 instruction per 2 cycles.
//  rvalid outside WAIT/DROP (e.g. stray response after reset) is ignored.
//  fetch_pc wraps modulo 2^32 (0xFFFFFFFC + 4 = 0).
// TESTING
//  1 Reset, gnt same cycle as req, rvalid 1 cycle later with rdata=0xE3A00001:
//    imem_addr=0; fetch_valid=1 for one cycle with pc_out=4, instruction_out=0xE3A00001;
//    next req addr=4.
//  2 freeze=1 across rvalid (rdata=0x11111111), release 3 cycles later:
//    outputs stable, fetch_valid=1, imem_req=0 while frozen; one consumption;
//    next req addr = prior+4.
//  3 Branch to 0x103 in WAIT, rvalid 3 cycles later:
//    response dropped, no fetch_valid; next req addr=0x100; first valid pc_out=0x104.
//  4 Branch to 0x200 in same cycle as gnt:
//    DROP entered; stale rvalid discarded; next req addr=0x200.
//  5 Branch + freeze together in HOLD:
//    fetch_valid=0 that cycle; buffer cleared; next cycle imem_req=1, imem_addr=branch target.
//  6 Async rst pulse mid-WAIT:
//    imem_req/fetch_valid drop immediately; later stray rvalid ignored;
//    next req addr=RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, keeps one request in flight to
// instruction memory, and feeds the IF/ID register under freeze/flush control.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_freeze,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_addr,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_pc_out,
    output logic [31:0] o_instruction_out,
    output logic        o_fetch_valid
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_hold_pc;
    logic [31:0] r_hold_instr;

    logic [31:0] w_target;
    logic [31:0] w_pc_next;
    logic        w_live;
    logic        w_hold;
    logic        w_valid;

    assign w_target  = {i_branch_addr[31:2], 2'b00};
    assign w_pc_next = r_fetch_pc + 32'd4;
    assign w_live    = (r_state == S_WAIT) && i_imem_rvalid;
    assign w_hold    = (r_state == S_HOLD);
    // A redirect squashes whatever is being presented in the same cycle.
    assign w_valid   = !i_branch_taken && (w_live || w_hold);

    assign o_imem_req        = (r_state == S_REQ) && !rst;
    assign o_imem_addr       = r_fetch_pc;
    assign o_fetch_valid     = w_valid;
    assign o_pc_out          = !w_valid ? 32'h0000_0000 :
                               (w_hold ? r_hold_pc : w_pc_next);
    assign o_instruction_out = !w_valid ? NOP_INSTR :
                               (w_hold ? r_hold_instr : i_imem_rdata);

    // Fetch state machine, PC and hold buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_REQ;
            r_fetch_pc   <= RESET_PC;
            r_hold_pc    <= 32'h0000_0000;
            r_hold_instr <= NOP_INSTR;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (i_branch_taken) begin
                        r_fetch_pc <= w_target;
                        r_state    <= i_imem_gnt ? S_DROP : S_REQ;
                    end else if (i_imem_gnt) begin
                        r_state <= S_WAIT;
                    end else begin
                        r_state <= S_REQ;
                    end
                end
                S_WAIT: begin
                    if (i_branch_taken) begin
                        r_fetch_pc <= w_target;
                        r_state    <= i_imem_rvalid ? S_REQ : S_DROP;
                    end else if (i_imem_rvalid && !i_freeze) begin
                        r_fetch_pc <= w_pc_next;
                        r_state    <= S_REQ;
                    end else if (i_imem_rvalid) begin
                        r_hold_pc    <= w_pc_next;
                        r_hold_instr <= i_imem_rdata;
                        r_state      <= S_HOLD;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_HOLD: begin
                    if (i_branch_taken) begin
                        r_fetch_pc   <= w_target;
                        r_hold_pc    <= 32'h0000_0000;
                        r_hold_instr <= NOP_INSTR;
                        r_state      <= S_REQ;
                    end else if (!i_freeze) begin
                        r_fetch_pc <= w_pc_next;
                        r_state    <= S_REQ;
                    end else begin
                        r_state <= S_HOLD;
                    end
                end
                S_DROP: begin
                    // The squashed response may land together with a new redirect;
                    // nothing else is outstanding then, so fetching can resume.
                    if (i_branch_taken) begin
                        r_fetch_pc <= w_target;
                    end
                    r_state <= i_imem_rvalid ? S_REQ : S_DROP;
                end
                default: begin
                    r_state <= S_REQ;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios, then randomized memory timing,
// freezes and redirects checked against a program-order model of the fetch stream.
module tb_if_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze, br, gnt, rvalid;
    logic [31:0] baddr, rdata;
    logic        imem_req, fetch_valid;
    logic [31:0] imem_addr, pc_out, instr_out;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_cons = 0;
    logic chk_data = 1'b0;
    logic [31:0] redirect_q[$];

    if_fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk(clk), .rst(rst),
        .i_freeze(freeze), .i_branch_taken(br), .i_branch_addr(baddr),
        .o_imem_req(imem_req), .o_imem_addr(imem_addr),
        .i_imem_gnt(gnt), .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
        .o_pc_out(pc_out), .o_instruction_out(instr_out), .o_fetch_valid(fetch_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fword(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic f, input logic b, input logic [31:0] ba,
                       input logic g, input logic rv, input logic [31:0] rd);
        freeze = f; br = b; baddr = ba; gnt = g; rvalid = rv; rdata = rd;
        if (b) redirect_q.push_back(ba);
    endtask

    // Monitor: the expected fetch stream is sequential from the last redirect or reset.
    initial begin : monitor
        logic [31:0] exp_pc;
        int idle;
        exp_pc = RESET_PC;
        idle   = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_pc = RESET_PC;
                idle   = 0;
            end else if (br) begin
                chk("branch_kills_valid", {31'd0, fetch_valid}, 32'd0);
                if (redirect_q.size() == 0) begin
                    chk("redirect_queue_empty", 32'd1, 32'd0);
                end else begin
                    exp_pc = redirect_q.pop_front() & 32'hFFFF_FFFC;
                end
            end else if (fetch_valid && !freeze) begin
                chk("consumed_pc", pc_out, exp_pc + 32'd4);
                if (chk_data) chk("consumed_instr", instr_out, fword(exp_pc));
                exp_pc = exp_pc + 32'd4;
                idle   = 0;
                n_cons++;
            end else if (chk_data) begin
                idle++;
                if (idle > 300) begin
                    chk("watchdog_no_progress", idle, 32'd0);
                    idle = 0;
                end
            end
            if (!rst && !fetch_valid) begin
                chk("idle_pc_zero", pc_out, 32'd0);
                chk("idle_instr_nop", instr_out, NOP_INSTR);
            end
        end
    end

    initial begin : timeout
        #1_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic        busy;
        logic        was_busy;
        int          cnt;
        logic [31:0] paddr;
        logic        f, b, g, rv;
        logic [31:0] ba, rd;

        rst = 1'b1;
        drv(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, fetch_valid}, 32'd0);
        chk("rst_pc", pc_out, 32'd0);
        chk("rst_instr", instr_out, NOP_INSTR);
        chk("rst_addr", imem_addr, RESET_PC);

        // 1: basic fetch
        step(); rst = 1'b0;
        drv(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0); #1;
        chk("t1_req", {31'd0, imem_req}, 32'd1);
        chk("t1_addr", imem_addr, 32'd0);
        step(); drv(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'hE3A0_0001); #1;
        chk("t1_valid", {31'd0, fetch_valid}, 32'd1);
        chk("t1_pc", pc_out, 32'd4);
        chk("t1_instr", instr_out, 32'hE3A0_0001);
        step(); drv(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0); #1;
        chk("t1_next_addr", imem_addr, 32'd4);
        chk("t1_after_valid", {31'd0, fetch_valid}, 32'd0);

        // 2: freeze across the response
        step(); drv(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'h1111_1111); #1;
        chk("t2_valid_on_rvalid", {31'd0, fetch_valid}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step(); drv(i < 2, 1'b0, 32'd0, 1'b0, 1'b0, $urandom); #1;
            chk("t2_hold_valid", {31'd0, fetch_valid}, 32'd1);
            chk("t2_hold_pc", pc_out, 32'd8);
            chk("t2_hold_instr", instr_out, 32'h1111_1111);
            chk("t2_hold_req", {31'd0, imem_req}, 32'd0);
        end
        step(); drv(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0); #1;
        chk("t2_next_addr", imem_addr, 32'd8);
        chk("t2_req", {31'd0, imem_req}, 32'd1);
        chk("t2_no_dup", {31'd0, fetch_valid}, 32'd0);

        // 3: redirect while waiting for the response
        step(); drv(1'b0, 1'b1, 32'h0000_0103, 1'b0, 1'b0, 32'd0); #1;
        chk("t3_branch_fv", {31'd0, fetch_valid}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            step(); drv(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0); #1;
            chk("t3_drop_req", {31'd0, imem_req}, 32'd0);
        end
        step(); drv(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'hDEAD_BEEF); #1;
        chk("t3_stale_fv", {31'd0, fetch_valid}, 32'd0);
        step(); drv(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0); #1;
        chk("t3_addr", imem_addr, 32'h0000_0100);
        chk("t3_req", {31'd0, imem_req}, 32'd1);
        step(); drv(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h1234_5678); #1;
        chk("t3_pc", pc_out, 32'h0000_0104);
        chk("t3_fv", {31'd0, fetch_valid}, 32'd1);

        // 4: redirect in the grant cycle
        step(); drv(1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b0, 32'd0); #1;
        chk("t4_addr_before", imem_addr, 32'h0000_0104);
        chk("t4_fv", {31'd0, fetch_valid}, 32'd0);
        step(); drv(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0); #1;
        chk("t4_drop_req", {31'd0, imem_req}, 32'd0);
        step(); drv(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'hCAFE_F00D); #1;
        chk("t4_stale_fv", {31'd0, fetch_valid}, 32'd0);
        step(); drv(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0); #1;
        chk("t4_addr", imem_addr, 32'h0000_0200);
        chk("t4_req", {31'd0, imem_req}, 32'd1);

        // 5: redirect plus freeze while holding
        step(); drv(1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'h2222_2222); #1;
        step(); drv(1'b1, 1'b1, 32'h0000_0300, 1'b0, 1'b0, 32'd0); #1;
        chk("t5_fv", {31'd0, fetch_valid}, 32'd0);
        step(); drv(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0); #1;
        chk("t5_req", {31'd0, imem_req}, 32'd1);
        chk("t5_addr", imem_addr, 32'h0000_0300);
        chk("t5_after_fv", {31'd0, fetch_valid}, 32'd0);

        // 6: asynchronous reset while waiting
        step(); drv(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0); #1;
        chk("t6_wait_req", {31'd0, imem_req}, 32'd0);
        rst = 1'b1; #1;
        chk("t6_rst_req", {31'd0, imem_req}, 32'd0);
        chk("t6_rst_fv", {31'd0, fetch_valid}, 32'd0);
        chk("t6_rst_addr", imem_addr, RESET_PC);
        step(); rst = 1'b0;
        drv(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'hBADB_AD00); #1;
        chk("t6_stray_fv", {31'd0, fetch_valid}, 32'd0);
        chk("t6_req", {31'd0, imem_req}, 32'd1);
        chk("t6_addr", imem_addr, RESET_PC);

        // PC wrap at the top of the address space
        step(); drv(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0); #1;
        step(); drv(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0); #1;
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        step(); drv(1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h0BAD_F00D); #1;
        chk("wrap_fv", {31'd0, fetch_valid}, 32'd1);
        chk("wrap_pc", pc_out, 32'd0);
        step(); drv(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0); #1;
        chk("wrap_next_addr", imem_addr, 32'd0);

        // Randomized phase: memory with variable grant and response latency
        chk_data = 1'b1;
        busy  = 1'b0;
        cnt   = 0;
        paddr = 32'd0;
        for (int c = 0; c < 4000; c++) begin
            step();
            was_busy = busy;
            rv = 1'b0;
            rd = $urandom;
            if (busy) begin
                if (cnt == 0) begin
                    rv   = 1'b1;
                    rd   = fword(paddr);
                    busy = 1'b0;
                end else begin
                    cnt--;
                end
            end else if ($urandom_range(0, 99) < 3) begin
                rv = 1'b1;
            end
            if (was_busy) chk("one_outstanding", {31'd0, imem_req}, 32'd0);
            f  = ($urandom_range(0, 99) < 30);
            b  = ($urandom_range(0, 99) < 5);
            ba = $urandom;
            g  = !was_busy && imem_req && ($urandom_range(0, 99) < 60);
            if (g) begin
                chk("req_addr_aligned", {30'd0, imem_addr[1:0]}, 32'd0);
                busy  = 1'b1;
                cnt   = $urandom_range(0, 2);
                paddr = imem_addr;
            end
            drv(f, b, ba, g, rv, rd);
        end
        step(); drv(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        repeat (4) step();
        chk("random_progress", {31'd0, n_cons > 100}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
